// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// Sequences loads and stores from the MEM stage onto a byte-enabled
// synchronous data memory (read data valid one cycle after its address).
// A word or halfword access that crosses a word boundary is either split
// into two aligned accesses and merged, or rejected with misalign_err,
// depending on the build option below.
//
// Build option:
//   DMEM_MISALIGN_SPLIT_EN  defined   : boundary-crossing accesses are split.
//                           undefined : they are rejected in one cycle with
//                                       misalign_err=1 and no memory access.
//
// Parameters:
//   DMEM_AW       data memory word-address width
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     MEM stage presents a request
//   req_ready     controller idle and able to accept
//   req_is_load   request is a load
//   req_is_store  request is a store
//   req_alucode   LB/LBU/LH/LHU/LW/SB/SH/SW operation code
//   req_addr      byte address
//   req_wdata     right-aligned store data
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data (0 for stores and rejected accesses)
//   misalign_err  pulses with resp_valid when an access is rejected
//   mem_addr      word address to the data memory
//   mem_we        byte write enables
//   mem_wdata     lane-shifted write data
//   mem_rdata     read data from the data memory
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_load,
    input  logic               req_is_store,
    input  logic [5:0]         req_alucode,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               misalign_err,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [3:0]         mem_we,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam logic       ENABLE  = 1'b1;
    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    localparam logic [DMEM_AW-1:0] A_ONE = 1;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_ISSUE1,
        S_CAPTURE,
        S_RESP
    } state_t;

    // Merge the two captured words, align the addressed bytes to bit 0 and
    // extend according to the load type.
    function automatic logic [31:0] f_load_result(
        input logic [5:0]  alu,
        input logic [1:0]  off,
        input logic [31:0] hi,
        input logic [31:0] lo
    );
        logic [31:0] w;
        w = 32'({hi, lo} >> {off, 3'b000});
        case (alu)
            ALU_LB:  f_load_result = {{24{w[7]}}, w[7:0]};
            ALU_LBU: f_load_result = {24'd0, w[7:0]};
            ALU_LH:  f_load_result = {{16{w[15]}}, w[15:0]};
            ALU_LHU: f_load_result = {16'd0, w[15:0]};
            default: f_load_result = w;
        endcase
    endfunction

    state_t               r_state;
    state_t               w_state_nx;

    logic [DMEM_AW-1:0]   r_mem_addr;
    logic [3:0]           r_mem_we;
    logic [31:0]          r_mem_wdata;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_rdata;
    logic                 r_misalign;

    logic [DMEM_AW-1:0]   w_addr_nx;
    logic [3:0]           w_we_nx;
    logic [31:0]          w_wdata_nx;
    logic                 w_resp_valid_nx;
    logic [31:0]          w_rdata_nx;
    logic                 w_misalign_nx;

    // Request fields captured at accept; only meaningful while busy.
    logic [5:0]           r_alu;
    logic [1:0]           r_off;
    logic [DMEM_AW-1:0]   r_word_a;
    logic                 r_is_load;
    logic                 r_split;
    logic [3:0]           r_we_hi;
    logic [31:0]          r_wdata_hi;
    logic [31:0]          r_lo;

    // Request decode
    logic                 w_ld_code;
    logic                 w_st_code;
    logic                 w_half;
    logic                 w_word;
    logic                 w_ld_ok;
    logic                 w_st_ok;
    logic                 w_accept;
    logic                 w_split;
    logic [1:0]           w_off;
    logic [DMEM_AW-1:0]   w_word_a;
    logic [3:0]           w_mask;
    logic [7:0]           w_m8;
    logic [63:0]          w_w64;
    logic                 w_addr_unused;

    assign w_off     = req_addr[1:0];
    assign w_word_a  = req_addr[DMEM_AW+1:2];
    // Byte address bits above the memory size are ignored.
    assign w_addr_unused = ^req_addr[31:DMEM_AW+2];

    assign w_ld_code = (req_alucode == ALU_LB)  || (req_alucode == ALU_LBU) ||
                       (req_alucode == ALU_LH)  || (req_alucode == ALU_LHU) ||
                       (req_alucode == ALU_LW);
    assign w_st_code = (req_alucode == ALU_SB)  || (req_alucode == ALU_SH) ||
                       (req_alucode == ALU_SW);
    assign w_half    = (req_alucode == ALU_LH)  || (req_alucode == ALU_LHU) ||
                       (req_alucode == ALU_SH);
    assign w_word    = (req_alucode == ALU_LW)  || (req_alucode == ALU_SW);

    assign w_ld_ok   = (req_is_load == ENABLE) && (req_is_store != ENABLE) && w_ld_code;
    assign w_st_ok   = (req_is_store == ENABLE) && (req_is_load != ENABLE) && w_st_code;
    assign w_accept  = req_valid && (w_ld_ok || w_st_ok);

    assign w_split   = (w_half && (w_off == 2'd3)) || (w_word && (w_off != 2'd0));
    assign w_mask    = w_word ? 4'b1111 : (w_half ? 4'b0011 : 4'b0001);
    // Low nibble/word serve the first access, high nibble/word the second.
    assign w_m8      = {4'b0000, w_mask} << w_off;
    assign w_w64     = {32'd0, req_wdata} << {w_off, 3'b000};

    always_comb begin
        w_state_nx      = r_state;
        w_addr_nx       = r_mem_addr;
        w_we_nx         = 4'b0000;
        w_wdata_nx      = r_mem_wdata;
        w_resp_valid_nx = 1'b0;
        w_rdata_nx      = r_resp_rdata;
        w_misalign_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_split && !SPLIT_EN) begin
                        // Rejected: answer next cycle, memory untouched.
                        w_state_nx      = S_RESP;
                        w_resp_valid_nx = 1'b1;
                        w_rdata_nx      = 32'd0;
                        w_misalign_nx   = 1'b1;
                    end else begin
                        w_state_nx = S_ISSUE0;
                        w_addr_nx  = w_word_a;
                        if (w_st_ok) begin
                            w_we_nx    = w_m8[3:0];
                            w_wdata_nx = w_w64[31:0];
                        end
                    end
                end
            end
            S_ISSUE0: begin
                if (r_split) begin
                    w_state_nx = S_ISSUE1;
                    w_addr_nx  = r_word_a + A_ONE;
                    if (!r_is_load) begin
                        w_we_nx    = r_we_hi;
                        w_wdata_nx = r_wdata_hi;
                    end
                end else if (r_is_load) begin
                    w_state_nx = S_CAPTURE;
                end else begin
                    w_state_nx      = S_RESP;
                    w_resp_valid_nx = 1'b1;
                    w_rdata_nx      = 32'd0;
                end
            end
            S_ISSUE1: begin
                if (r_is_load) begin
                    w_state_nx = S_CAPTURE;
                end else begin
                    w_state_nx      = S_RESP;
                    w_resp_valid_nx = 1'b1;
                    w_rdata_nx      = 32'd0;
                end
            end
            S_CAPTURE: begin
                // mem_rdata now holds the last issued word (the only word for
                // an aligned load, the upper word for a split one).
                w_state_nx      = S_RESP;
                w_resp_valid_nx = 1'b1;
                w_rdata_nx      = f_load_result(r_alu, r_off,
                                                r_split ? mem_rdata : 32'd0,
                                                r_split ? r_lo : mem_rdata);
            end
            S_RESP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_addr   <= '0;
            r_mem_we     <= 4'b0000;
            r_mem_wdata  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_mem_addr   <= w_addr_nx;
            r_mem_we     <= w_we_nx;
            r_mem_wdata  <= w_wdata_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_rdata <= w_rdata_nx;
            r_misalign   <= w_misalign_nx;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && w_accept) begin
            r_alu      <= req_alucode;
            r_off      <= w_off;
            r_word_a   <= w_word_a;
            r_is_load  <= w_ld_ok;
            r_split    <= w_split;
            r_we_hi    <= w_m8[7:4];
            r_wdata_hi <= w_w64[63:32];
        end
        // First word of a split load arrives while the second is issued.
        if (r_state == S_ISSUE1) begin
            r_lo <= mem_rdata;
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign misalign_err = r_misalign;
    assign mem_addr     = r_mem_addr;
    assign mem_we       = r_mem_we;
    assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized
// loads/stores checked against a byte-level reference memory.
module tb_dmem_access_ctrl;

    localparam int AW = 14;
    localparam int NW = 1 << AW;
    localparam logic [31:0] BMASK = (32'd1 << (AW + 2)) - 32'd1;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_load;
    logic          req_is_store;
    logic [5:0]    req_alucode;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          misalign_err;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_total;
    int n_bad;

    dmem_access_ctrl #(.DMEM_AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_load  (req_is_load),
        .req_is_store (req_is_store),
        .req_alucode  (req_alucode),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign_err (misalign_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory seen by the DUT, and the reference memory of the model.
    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];

    always @(posedge clk) begin
        logic [31:0] nw;
        nw = mem[mem_addr];
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) nw[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr] <= nw;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [3:0]    we;
        logic [31:0]   d;
    } wr_t;
    wr_t wlog[$];
    int  resp_cnt;

    always @(posedge clk) begin
        if (mem_we != 4'b0000) wlog.push_back('{a: mem_addr, we: mem_we, d: mem_wdata});
        if (resp_valid) resp_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [5:0] op);
        if (op == ALU_LB || op == ALU_LBU || op == ALU_SB) return 1;
        if (op == ALU_LH || op == ALU_LHU || op == ALU_SH) return 2;
        return 4;
    endfunction

    function automatic bit op_load(input logic [5:0] op);
        return (op == ALU_LB || op == ALU_LBU || op == ALU_LH ||
                op == ALU_LHU || op == ALU_LW);
    endfunction

    // An access is split when its bytes do not all fit in one word.
    function automatic bit crosses(input logic [5:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) + op_size(op)) > 4;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] ba);
        logic [31:0] w;
        w = ref_mem[ba[AW+1:2]];
        return 8'(w >> (8 * ba[1:0]));
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wd, input int nbytes);
        logic [31:0] ba;
        logic [31:0] w;
        for (int i = 0; i < nbytes; i++) begin
            ba = (addr + 32'(i)) & BMASK;
            w  = ref_mem[ba[AW+1:2]];
            w  = (w & ~(32'hFF << (8 * ba[1:0]))) | ((32'(8'(wd >> (8 * i)))) << (8 * ba[1:0]));
            ref_mem[ba[AW+1:2]] = w;
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
        logic [31:0] v;
        int sz;
        sz = op_size(op);
        v  = 32'd0;
        for (int i = 0; i < sz; i++)
            v = v | (32'(ref_byte((addr + 32'(i)) & BMASK)) << (8 * i));
        if ((op == ALU_LB || op == ALU_LH) && v[8*sz-1])
            v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    // ---------------- transaction tasks ----------------
    task automatic do_req(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        bit ld, sp, mis;
        int exp_lat, exp_nw, n;
        logic [31:0] exp_rd;
        ld  = op_load(op);
        sp  = crosses(op, addr);
        mis = sp && !SPLIT_EN;
        exp_rd  = (ld && !mis) ? ref_load(op, addr) : 32'd0;
        exp_lat = mis ? 1 : (ld ? (sp ? 4 : 3) : (sp ? 3 : 2));
        exp_nw  = (ld || mis) ? 0 : (sp ? 2 : 1);
        if (!ld && !mis) ref_store(addr, wd, op_size(op));

        @(negedge clk);
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        wlog.delete();
        req_valid    = 1'b1;
        req_is_load  = ld;
        req_is_store = !ld;
        req_alucode  = op;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        n = 1;
        while (!resp_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
        chk({tag, ".rdata"}, 64'(resp_rdata), 64'(exp_rd));
        chk({tag, ".misalign"}, 64'(misalign_err), 64'(mis));
        @(posedge clk);
        #1;
        chk({tag, ".resp_once"}, 64'(resp_valid), 64'd0);
        chk({tag, ".rdata_hold"}, 64'(resp_rdata), 64'(exp_rd));
        chk({tag, ".nwrites"}, 64'(wlog.size()), 64'(exp_nw));
    endtask

    task automatic do_invalid(input int kind);
        int rc0;
        @(negedge clk);
        wlog.delete();
        rc0 = resp_cnt;
        req_valid = 1'b1;
        req_addr  = $urandom;
        req_wdata = $urandom;
        case (kind)
            0:       begin req_is_load = 1; req_is_store = 1; req_alucode = ALU_LW;  end
            1:       begin req_is_load = 0; req_is_store = 0; req_alucode = ALU_SW;  end
            2:       begin req_is_load = 1; req_is_store = 0; req_alucode = ALU_SW;  end
            3:       begin req_is_load = 0; req_is_store = 1; req_alucode = ALU_LBU; end
            default: begin req_is_load = 1; req_is_store = 0; req_alucode = 6'd0;    end
        endcase
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("inv.ready", 64'(req_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("inv.no_resp", 64'(resp_cnt - rc0), 64'd0);
        chk("inv.no_write", 64'(wlog.size()), 64'd0);
    endtask

    // Start a store, then assert reset after the given number of extra edges.
    task automatic do_reset_mid(input logic [31:0] addr, input logic [31:0] wd,
                                input int edges, input int exp_bytes, input int exp_writes);
        int rc0;
        @(negedge clk);
        wlog.delete();
        rc0 = resp_cnt;
        req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
        req_alucode = ALU_SW; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid.ready", 64'(req_ready), 64'd1);
        chk("rstmid.resp", 64'(resp_valid), 64'd0);
        chk("rstmid.we", 64'(mem_we), 64'd0);
        ref_store(addr, wd, exp_bytes);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid.no_resp", 64'(resp_cnt - rc0), 64'd0);
        chk("rstmid.nwrites", 64'(wlog.size()), 64'(exp_writes));
    endtask

    function automatic wr_t wget(input int i);
        wr_t z;
        z = '0;
        if (i < wlog.size()) z = wlog[i];
        return z;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] ops [8];

    initial begin
        logic [31:0] a;
        logic [31:0] r;
        wr_t e;
        n_total = 0; n_bad = 0; resp_cnt = 0;
        ops = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_SB, ALU_SH, ALU_SW};
        rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_alucode = 6'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < NW; i++) begin
            r = $urandom;
            mem[i] = r;
            ref_mem[i] = r;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk("rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rst.rdata", 64'(resp_rdata), 64'd0);
        chk("rst.misalign", 64'(misalign_err), 64'd0);
        chk("rst.we", 64'(mem_we), 64'd0);
        chk("rst.addr", 64'(mem_addr), 64'd0);
        chk("rst.wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Byte loads with sign/zero extension
        mem[5] = 32'h8899AABB; ref_mem[5] = 32'h8899AABB;
        do_req(ALU_LB,  32'h16, 32'd0, "lb");
        do_req(ALU_LBU, 32'h16, 32'd0, "lbu");

        // Halfword store into the upper lanes
        do_req(ALU_SH, 32'h12, 32'h0000_1234, "sh");
        e = wget(0);
        chk("sh.addr", 64'(e.a), 64'd4);
        chk("sh.we", 64'(e.we), 64'b1100);
        chk("sh.wdata", 64'(e.d), 64'h1234_0000);

        // Word load across a boundary
        mem[2] = 32'h44332211; ref_mem[2] = 32'h44332211;
        mem[3] = 32'h88776655; ref_mem[3] = 32'h88776655;
        do_req(ALU_LW, 32'h0B, 32'd0, "lw_x");

        // Word store across a boundary
        do_req(ALU_SW, 32'h0E, 32'hDDCC_BBAA, "sw_x");
`ifdef DMEM_MISALIGN_SPLIT_EN
        e = wget(0);
        chk("sw_x.a0", 64'(e.a), 64'd3);
        chk("sw_x.we0", 64'(e.we), 64'b1100);
        chk("sw_x.d0", 64'(e.d), 64'hBBAA_0000);
        e = wget(1);
        chk("sw_x.a1", 64'(e.a), 64'd4);
        chk("sw_x.we1", 64'(e.we), 64'b0011);
        chk("sw_x.d1", 64'(e.d), 64'h0000_DDCC);
`endif

        // Split store at the top word wraps to word 0
        do_req(ALU_SW, 32'h0000_FFFE, 32'h1357_9BDF, "sw_wrap");
`ifdef DMEM_MISALIGN_SPLIT_EN
        e = wget(0);
        chk("wrap.a0", 64'(e.a), 64'(NW - 1));
        e = wget(1);
        chk("wrap.a1", 64'(e.a), 64'd0);
        chk("wrap.we1", 64'(e.we), 64'b0011);
`endif
        do_req(ALU_LW, 32'h0000_FFFC, 32'd0, "wrap_rd_top");
        do_req(ALU_LW, 32'h0000_0000, 32'd0, "wrap_rd_0");

        // Reset in the middle of a store
`ifdef DMEM_MISALIGN_SPLIT_EN
        do_reset_mid(32'h1E, 32'hCAFE_F00D, 1, 2, 1);
`else
        do_reset_mid(32'h20, 32'hCAFE_F00D, 0, 0, 0);
`endif
        do_req(ALU_LW, 32'h1C, 32'd0, "rstmid_rd_a");
        do_req(ALU_LW, 32'h20, 32'd0, "rstmid_rd_b");

        for (int k = 0; k < 5; k++) do_invalid(k);

        // Randomized traffic over a small region and the wrap region
        for (int t = 0; t < 300; t++) begin
            if (t % 11 == 5) do_invalid(t % 5);
            if ($urandom_range(0, 3) == 0)
                a = ($urandom & 32'hFFFF_0000) | (32'h0000_FFF0 + 32'($urandom_range(0, 15)));
            else
                a = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 63));
            do_req(ops[$urandom_range(0, 7)], a, $urandom, "rnd");
        end

        for (int i = 0; i < 20; i++) chk("final_mem_lo", 64'(mem[i]), 64'(ref_mem[i]));
        for (int i = NW - 4; i < NW; i++) chk("final_mem_hi", 64'(mem[i]), 64'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
